// File: rtl/priority_arbiter.sv
// East/west request arbiter with emergency preemption and starvation limit.
// Decisions are taken at phase boundaries and every output is registered.
module priority_arbiter #(
  parameter bit PRIO_SIDE = 1'b0,
  parameter int MAX_WAIT  = 3,
  parameter int WAIT_W    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_east,
  input  logic       req_west,
  input  logic       emerg_east,
  input  logic       emerg_west,
  input  logic       timing_done,
  output logic [1:0] prio,
  output logic       preempt,
  output logic       pend_east,
  output logic       pend_west,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    SERVE_E = 3'b001,
    SERVE_W = 3'b010,
    PRE_E   = 3'b101,
    PRE_W   = 3'b110
  } state_t;

  localparam logic [WAIT_W-1:0] MAX_W   = WAIT_W'(MAX_WAIT);
  localparam state_t            FAV_SRV = (PRIO_SIDE == 1'b0) ? SERVE_E : SERVE_W;
  localparam state_t            NFV_SRV = (PRIO_SIDE == 1'b0) ? SERVE_W : SERVE_E;
  localparam state_t            FAV_PRE = (PRIO_SIDE == 1'b0) ? PRE_E : PRE_W;

  state_t            state_q, state_d, arb_state_s;
  logic [1:0]        prio_q, prio_d;
  logic              preempt_q, preempt_d;
  logic              pend_east_q, pend_east_d, pend_west_q, pend_west_d;
  logic [WAIT_W-1:0] wait_east_q, wait_east_d, wait_west_q, wait_west_d;
  logic [WAIT_W-1:0] nfv_wait_s;
  logic              arb_s;

  // Outcome of an arbitration, should this edge turn out to be one.
  always_comb begin
    nfv_wait_s  = (PRIO_SIDE == 1'b0) ? wait_west_q : wait_east_q;
    arb_state_s = IDLE;
    if (pend_east_q && !pend_west_q) begin
      arb_state_s = SERVE_E;
    end else if (!pend_east_q && pend_west_q) begin
      arb_state_s = SERVE_W;
    end else if (pend_east_q && pend_west_q) begin
      if (nfv_wait_s == MAX_W) begin
        arb_state_s = NFV_SRV;
      end else begin
        arb_state_s = FAV_SRV;
      end
    end else begin
      arb_state_s = IDLE;
    end
  end

  // Next state: emergencies first, then phase-boundary arbitration.
  always_comb begin
    state_d = state_q;
    arb_s   = 1'b0;
    case (state_q)
      PRE_E: begin
        if (emerg_east) begin
          state_d = PRE_E;
        end else if (timing_done) begin
          if (emerg_west) begin
            state_d = PRE_W;
          end else begin
            arb_s   = 1'b1;
            state_d = arb_state_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      PRE_W: begin
        if (emerg_west) begin
          state_d = PRE_W;
        end else if (timing_done) begin
          if (emerg_east) begin
            state_d = PRE_E;
          end else begin
            arb_s   = 1'b1;
            state_d = arb_state_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      IDLE, SERVE_E, SERVE_W: begin
        if (emerg_east && emerg_west) begin
          state_d = FAV_PRE;
        end else if (emerg_east) begin
          state_d = PRE_E;
        end else if (emerg_west) begin
          state_d = PRE_W;
        end else if (timing_done) begin
          arb_s   = 1'b1;
          state_d = arb_state_s;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode, sticky pending flags and starvation counters.
  always_comb begin
    case (state_d)
      SERVE_E, PRE_E: prio_d = 2'b01;
      SERVE_W, PRE_W: prio_d = 2'b10;
      default:        prio_d = 2'b00;
    endcase
    preempt_d   = (state_d == PRE_E || state_d == PRE_W) && (state_d != state_q);
    // A request on the granting edge re-arms the flag.
    pend_east_d = req_east | (pend_east_q & ~(arb_s & (arb_state_s == SERVE_E)));
    pend_west_d = req_west | (pend_west_q & ~(arb_s & (arb_state_s == SERVE_W)));
    if (!arb_s) begin
      wait_east_d = wait_east_q;
      wait_west_d = wait_west_q;
    end else begin
      if (arb_state_s == SERVE_E || !pend_east_q) begin
        wait_east_d = '0;
      end else if (wait_east_q == MAX_W) begin
        wait_east_d = MAX_W;
      end else begin
        wait_east_d = wait_east_q + WAIT_W'(1'b1);
      end
      if (arb_state_s == SERVE_W || !pend_west_q) begin
        wait_west_d = '0;
      end else if (wait_west_q == MAX_W) begin
        wait_west_d = MAX_W;
      end else begin
        wait_west_d = wait_west_q + WAIT_W'(1'b1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 2'b00;
      preempt_q   <= 1'b0;
      pend_east_q <= 1'b0;
      pend_west_q <= 1'b0;
      wait_east_q <= '0;
      wait_west_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      preempt_q   <= preempt_d;
      pend_east_q <= pend_east_d;
      pend_west_q <= pend_west_d;
      wait_east_q <= wait_east_d;
      wait_west_q <= wait_west_d;
    end
  end

  assign prio      = prio_q;
  assign preempt   = preempt_q;
  assign pend_east = pend_east_q;
  assign pend_west = pend_west_q;
  assign state     = state_q;

endmodule
